// File: rtl/uart_tx.sv
// uart_tx: serialises one PAYLOAD_BITS-wide word per request as an
// asynchronous frame: start bit (0), payload LSB first, STOP_BITS stop bits (1).
// The line and busy flag are registered and derived from the next state, so
// they change exactly on the edge where the FSM changes state.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  // Derived timing; truncating divide is the only source of bit-period error.
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT * STOP_BITS + 1);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  // Last count value of a single bit period and of the whole stop period.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CYCLES_PER_BIT * STOP_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;

  // State, counters, shift register and registered outputs; reset abandons any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: bit timing, payload shifting and frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (uart_tx_en) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          sr_d    = uart_tx_data;
        end else begin
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            sr_d    = sr_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        sr_d    = '0;
      end
    endcase
  end

  // Output levels follow the state being entered so they line up with the edge.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sr_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a time-based line model checks every cycle, plus a table
// of frames, an ignored request, back-to-back frames, a mid-frame reset and a
// 7-data-bit / 2-stop-bit variant at the real 50 MHz / 9600 baud timing.
module tb_uart_tx;

  localparam int CLK_HZ   = 1300;
  localparam int BIT_RATE = 300;
  localparam int CPB      = CLK_HZ / BIT_RATE;       // 4 (truncated from 4.33)
  localparam int FRAME    = (1 + 8 + 1) * CPB;

  localparam int V_CLK    = 50000000;
  localparam int V_RATE   = 9600;
  localparam int V_CPB    = V_CLK / V_RATE;          // 5208
  localparam int V_FRAME  = (1 + 7 + 2) * V_CPB;     // 52080

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       txd, busy;
  logic       v_en   = 1'b0;
  logic [6:0] v_data = 7'h00;
  logic       v_txd, v_busy;

  int checks = 0;
  int passes = 0;

  uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .uart_txd(txd), .uart_tx_busy(busy),
    .uart_tx_en(en), .uart_tx_data(data)
  );

  uart_tx #(.BIT_RATE(V_RATE), .CLK_HZ(V_CLK), .PAYLOAD_BITS(7), .STOP_BITS(2)) dut_v (
    .clk(clk), .reset(reset), .uart_txd(v_txd), .uart_tx_busy(v_busy),
    .uart_tx_en(v_en), .uart_tx_data(v_data)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Line level t cycles after the accept edge, from the frame layout alone.
  function automatic logic line_level(input int t, input int cpb, input int pb,
                                      input int sb, input logic [15:0] d);
    int slot;
    slot = t / cpb;
    if (t < 0 || slot >= 1 + pb + sb) return 1'b1;
    if (slot == 0) return 1'b0;
    if (slot <= pb) return d[slot-1];
    return 1'b1;
  endfunction

  // Expected {txd, busy} of the main DUT.
  function automatic int exp_line(input bit act, input int t, input logic [7:0] d);
    if (!act || t >= FRAME) return 2;
    return {30'd0, line_level(t, CPB, 8, 1, {8'h00, d}), 1'b1};
  endfunction

  // Reference model: edge count, time of last accept, and the accepted word.
  int         cyc      = 0;
  int         m_n      = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_data   = 8'h00;

  // Model update: a request is taken only once the previous frame has fully ended.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (en && (!m_active || (cyc + 1 - m_n) >= FRAME + 1)) begin
        m_active <= 1'b1;
        m_n      <= cyc + 1;
        m_data   <= data;
      end
    end
  end

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    check("line", int'({txd, busy}), exp_line(m_active, cyc - m_n, m_data));
  end

  // One request, then watch the frame; optional extra request pulse at pulse_t.
  task automatic send_frame(input logic [7:0] d, input int pulse_t, input logic [7:0] pulse_d,
                            output logic [9:0] slots, output int busy_len, output int late_busy);
    @(negedge clk);
    en   = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    en   = 1'b0;
    data = 8'($urandom);
    slots     = '0;
    busy_len  = 0;
    late_busy = 0;
    for (int t = 0; t < 3 * FRAME; t++) begin
      @(negedge clk);
      if (t < FRAME + 2) begin
        if (busy) busy_len++;
      end else if (busy) begin
        late_busy++;
      end
      if (t < 10 * CPB && (t % CPB) == CPB / 2) slots[t / CPB] = txd;
      if (t == pulse_t) begin
        en   = 1'b1;
        data = pulse_d;
      end else begin
        en   = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit s = line level in slot s (start, d0..d7, stop)
  } vec_t;

  vec_t       vecs [7];
  logic [9:0] slots;
  int         bl, lb;
  logic [7:0] b2b [4];
  int         starts [$];
  logic       hist [0:399];
  logic       prev;
  logic [7:0] rx;
  int         vbusy, vstop, vbad;
  logic [6:0] vrx;

  initial begin
    vecs[0] = '{data: 8'h41, frame: 10'b1_01000001_0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    vecs[3] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    vecs[4] = '{data: 8'h5A, frame: 10'b1_01011010_0};
    vecs[5] = '{data: 8'h80, frame: 10'b1_10000000_0};
    vecs[6] = '{data: 8'h01, frame: 10'b1_00000001_0};
    b2b[0] = 8'h41; b2b[1] = 8'h31; b2b[2] = 8'h42; b2b[3] = 8'h32;

    // Reset held, then 1000 idle cycles.
    repeat (3) @(negedge clk);
    check("reset_txd", int'(txd), 1);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_txd", int'(txd), 1);
    check("idle_busy", int'(busy), 0);

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, -1, 8'h00, slots, bl, lb);
      check("frame", int'(slots), int'(vecs[i].frame));
      check("busy_len", bl, FRAME);
      check("no_extra_frame", lb, 0);
    end

    // Request during data bit 3 of 0x55 must be dropped.
    send_frame(8'h55, 4 * CPB + 1, 8'hAA, slots, bl, lb);
    check("ignored_frame", int'(slots), int'(10'b1_01010101_0));
    check("ignored_busy_len", bl, FRAME);
    check("ignored_no_second", lb, 0);

    // Back-to-back frames with the request held high.
    @(negedge clk);
    en   = 1'b1;
    data = b2b[0];
    prev = 1'b0;
    for (int c = 0; c < 4 * (FRAME + 1) + 20; c++) begin
      @(negedge clk);
      hist[c] = txd;
      if (busy && !prev) begin
        starts.push_back(c);
        if (starts.size() < 4) data = b2b[starts.size()];
        else en = 1'b0;
      end
      prev = busy;
    end
    en = 1'b0;
    check("b2b_count", starts.size(), 4);
    if (starts.size() == 4) begin
      for (int k = 1; k < 4; k++) check("b2b_period", starts[k] - starts[k-1], FRAME + 1);
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 8; j++) rx[j] = hist[starts[k] + (1 + j) * CPB + CPB / 2];
        check("b2b_rx", int'(rx), int'(b2b[k]));
      end
    end
    repeat (FRAME) @(negedge clk);

    // Random request traffic, checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
    end
    en = 1'b0;
    repeat (FRAME + 2) @(negedge clk);

    // Asynchronous reset in data bit 4 of 0xF0, then a clean 0x0F frame.
    @(negedge clk);
    en   = 1'b1;
    data = 8'hF0;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (22) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_txd", int'(txd), 1);
    check("midreset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h0F, -1, 8'h00, slots, bl, lb);
    check("after_reset_frame", int'(slots), int'(10'b1_00001111_0));
    check("after_reset_busy_len", bl, FRAME);

    // Variant: 7 data bits, 2 stop bits, 50 MHz / 9600.
    @(negedge clk);
    v_en   = 1'b1;
    v_data = 7'h7F;
    @(posedge clk);
    #1;
    v_en   = 1'b0;
    v_data = 7'h00;
    vbusy = 0; vstop = 0; vbad = 0; vrx = '0;
    for (int t = 0; t < V_FRAME + 100; t++) begin
      @(negedge clk);
      if (v_busy) vbusy++;
      if (v_txd !== line_level(t, V_CPB, 7, 2, 16'h007F)) vbad++;
      if (v_busy && v_txd && t >= 8 * V_CPB) vstop++;
      if (t >= V_CPB && t < 8 * V_CPB && (t % V_CPB) == V_CPB / 2) vrx[t / V_CPB - 1] = v_txd;
    end
    check("v_busy_len", vbusy, V_FRAME);
    check("v_stop_len", vstop, 2 * V_CPB);
    check("v_line_bad_cycles", vbad, 0);
    check("v_rx", int'(vrx), 32'h7F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
